// File: rtl/if_id_hazard.sv
// rtl/if_id_hazard.sv - IF/ID pipeline register with load-use stall, branch flush and memory freeze
module if_id_hazard #(
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc_in,
    input  logic [31:0]      instr_in,
    input  logic             instr_valid_in,
    input  logic             id_ex_MR,
    input  logic [3:0]       id_ex_WN,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic [31:0]      pc_out,
    output logic [31:0]      instr_out,
    output logic             valid_out,
    output logic [3:0]       RN1_out,
    output logic [3:0]       RN2_out,
    output logic [3:0]       WN_out,
    output logic             stall,
    output logic             pc_write,
    output logic             bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic       hazard;
    logic       load;
    logic       flush;
    logic       count_stall;

    assign RN1_out = instr_out[23:20];
    assign RN2_out = instr_out[19:16];
    assign WN_out  = instr_out[27:24];

    // r0 is hardwired zero, so a load targeting it can never feed a dependent read
    assign hazard = valid_out & id_ex_MR & (id_ex_WN != 4'd0) &
                    ((id_ex_WN == RN1_out) | (id_ex_WN == RN2_out));

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        stall   = 1'b0;
        load    = 1'b0;
        flush   = 1'b0;
        if (branch_taken) begin
            flush   = 1'b1;
            state_n = RUN;
            cnt_n   = 4'd0;
        end else begin
            stall = (state == STALL) | hazard;
            if (!mem_busy) begin
                if (state == RUN) begin
                    if (hazard) begin
                        if (STALL_CYCLES > 1) begin
                            state_n = STALL;
                            cnt_n   = 4'(STALL_CYCLES - 1);
                        end
                    end else begin
                        load = 1'b1;
                    end
                end else begin
                    cnt_n = cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state_n = RUN;
                    end
                end
            end
        end
    end

    assign pc_write    = branch_taken | (~mem_busy & ~stall);
    assign bubble      = stall | mem_busy | branch_taken;
    assign count_stall = stall & ~mem_busy & ~branch_taken;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_out    <= 32'd0;
            instr_out <= 32'd0;
            valid_out <= 1'b0;
        end else if (flush) begin
            pc_out    <= pc_in;
            instr_out <= 32'd0;
            valid_out <= 1'b0;
        end else if (load) begin
            pc_out    <= pc_in;
            instr_out <= instr_in;
            valid_out <= instr_valid_in;
        end
    end

    // Performance counters stick at all-ones rather than wrapping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (count_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (branch_taken && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_if_id_hazard.sv
// tb/tb_if_id_hazard.sv - scoreboard bench for if_id_hazard (1-cycle and 3-cycle stall instances)
module tb_if_id_hazard;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        iv;
        logic        mr;
        logic [3:0]  wn;
        logic        br;
        logic        busy;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic [3:0]  rn1;
        logic [3:0]  rn2;
        logic [3:0]  wn;
        logic        stall;
        logic        pc_write;
        logic        bubble;
        logic [15:0] scnt;
        logic [15:0] fcnt;
    } obs_t;

    typedef struct packed {
        logic [15:0] id;
        logic        sel;
        obs_t        exp;
    } ent_t;

    localparam logic [31:0] I1 = 32'h1534_0000;
    localparam logic [31:0] I2 = 32'h2608_0000;
    localparam logic [31:0] I3 = 32'h3A12_0000;

    logic  clk;
    logic  rst;
    stim_t in_a, in_b;
    obs_t  obs_a, obs_b;
    ent_t  sb[$];
    int    checks;
    int    failures;
    int    step_id;

    logic [31:0] pc_a, instr_a, pc_b, instr_b;
    logic        v_a, st_a, pw_a, bub_a, v_b, st_b, pw_b, bub_b;
    logic [3:0]  rn1_a, rn2_a, wn_a, rn1_b, rn2_b, wn_b;
    logic [15:0] sc_a, fc_a;
    logic [2:0]  sc_b, fc_b;

    if_id_hazard #(.STALL_CYCLES(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(rst),
        .pc_in(in_a.pc), .instr_in(in_a.instr), .instr_valid_in(in_a.iv),
        .id_ex_MR(in_a.mr), .id_ex_WN(in_a.wn), .branch_taken(in_a.br), .mem_busy(in_a.busy),
        .pc_out(pc_a), .instr_out(instr_a), .valid_out(v_a),
        .RN1_out(rn1_a), .RN2_out(rn2_a), .WN_out(wn_a),
        .stall(st_a), .pc_write(pw_a), .bubble(bub_a),
        .stall_cnt(sc_a), .flush_cnt(fc_a)
    );

    if_id_hazard #(.STALL_CYCLES(3), .CNT_W(3)) dut_b (
        .clk(clk), .reset(rst),
        .pc_in(in_b.pc), .instr_in(in_b.instr), .instr_valid_in(in_b.iv),
        .id_ex_MR(in_b.mr), .id_ex_WN(in_b.wn), .branch_taken(in_b.br), .mem_busy(in_b.busy),
        .pc_out(pc_b), .instr_out(instr_b), .valid_out(v_b),
        .RN1_out(rn1_b), .RN2_out(rn2_b), .WN_out(wn_b),
        .stall(st_b), .pc_write(pw_b), .bubble(bub_b),
        .stall_cnt(sc_b), .flush_cnt(fc_b)
    );

    assign obs_a = '{pc: pc_a, instr: instr_a, valid: v_a, rn1: rn1_a, rn2: rn2_a, wn: wn_a,
                     stall: st_a, pc_write: pw_a, bubble: bub_a, scnt: sc_a, fcnt: fc_a};
    assign obs_b = '{pc: pc_b, instr: instr_b, valid: v_b, rn1: rn1_b, rn2: rn2_b, wn: wn_b,
                     stall: st_b, pc_write: pw_b, bubble: bub_b,
                     scnt: {13'd0, sc_b}, fcnt: {13'd0, fc_b}};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t s_(logic [31:0] pc, logic [31:0] ins, logic iv, logic mr,
                                 logic [3:0] wn, logic br, logic busy);
        s_ = '{pc: pc, instr: ins, iv: iv, mr: mr, wn: wn, br: br, busy: busy};
    endfunction

    function automatic obs_t e_(logic [31:0] pc, logic [31:0] ins, logic v, logic st,
                                logic pw, logic bub, logic [15:0] sc, logic [15:0] fc);
        e_ = '{pc: pc, instr: ins, valid: v, rn1: ins[23:20], rn2: ins[19:16], wn: ins[27:24],
               stall: st, pc_write: pw, bubble: bub, scnt: sc, fcnt: fc};
    endfunction

    // Drive one cycle of stimulus just after the edge and queue the expected mid-cycle view
    task automatic step(input logic sel, input logic r, input stim_t s, input obs_t e);
        @(posedge clk);
        #1;
        rst = r;
        if (sel) begin
            in_b = s;
            in_a = '0;
        end else begin
            in_a = s;
            in_b = '0;
        end
        sb.push_back('{id: 16'(step_id), sel: sel, exp: e});
        step_id++;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            ent_t  ent;
            obs_t  act;
            ent = sb.pop_front();
            act = ent.sel ? obs_b : obs_a;
            checks++;
            if (act !== ent.exp) begin
                failures++;
                $display("FAIL step%0d dut_%s actual pc=%h ins=%h v=%b rn=%h/%h/%h st=%b pw=%b bub=%b sc=%0d fc=%0d required pc=%h ins=%h v=%b rn=%h/%h/%h st=%b pw=%b bub=%b sc=%0d fc=%0d",
                         ent.id, ent.sel ? "b" : "a",
                         act.pc, act.instr, act.valid, act.rn1, act.rn2, act.wn, act.stall,
                         act.pc_write, act.bubble, act.scnt, act.fcnt,
                         ent.exp.pc, ent.exp.instr, ent.exp.valid, ent.exp.rn1, ent.exp.rn2,
                         ent.exp.wn, ent.exp.stall, ent.exp.pc_write, ent.exp.bubble,
                         ent.exp.scnt, ent.exp.fcnt);
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        step_id  = 0;
        rst      = 1'b1;
        in_a     = '0;
        in_b     = '0;

        step(0, 1, s_(0, 0, 0, 0, 0, 0, 0), e_(0, 0, 0, 0, 1, 0, 0, 0));
        step(1, 1, s_(0, 0, 0, 0, 0, 0, 0), e_(0, 0, 0, 0, 1, 0, 0, 0));

        // one-cycle load-use penalty, r0 / non-load / invalid slot exemptions, branch flush
        step(0, 0, s_(32'h100, I1, 1, 0, 0, 0, 0), e_(0, 0, 0, 0, 1, 0, 0, 0));
        step(0, 0, s_(32'h104, I2, 1, 1, 3, 0, 0), e_(32'h100, I1, 1, 1, 0, 1, 0, 0));
        step(0, 0, s_(32'h104, I2, 1, 0, 0, 0, 0), e_(32'h100, I1, 1, 0, 1, 0, 1, 0));
        step(0, 0, s_(32'h108, I3, 1, 1, 0, 0, 0), e_(32'h104, I2, 1, 0, 1, 0, 1, 0));
        step(0, 0, s_(32'h10C, I1, 0, 0, 1, 0, 0), e_(32'h108, I3, 1, 0, 1, 0, 1, 0));
        step(0, 0, s_(32'h110, I2, 1, 1, 3, 0, 0), e_(32'h10C, I1, 0, 0, 1, 0, 1, 0));
        step(0, 0, s_(32'h114, I3, 1, 1, 8, 0, 0), e_(32'h110, I2, 1, 1, 0, 1, 1, 0));
        step(0, 0, s_(32'h114, I3, 1, 0, 0, 0, 0), e_(32'h110, I2, 1, 0, 1, 0, 2, 0));
        step(0, 0, s_(32'h200, I1, 1, 1, 1, 1, 0), e_(32'h114, I3, 1, 0, 1, 1, 2, 0));
        step(0, 0, s_(0, 0, 0, 0, 0, 0, 0),       e_(32'h200, 0, 0, 0, 1, 0, 2, 1));

        // three-cycle penalty
        step(1, 0, s_(32'h300, I1, 1, 0, 0, 0, 0), e_(0, 0, 0, 0, 1, 0, 0, 0));
        step(1, 0, s_(32'h304, I2, 1, 1, 3, 0, 0), e_(32'h300, I1, 1, 1, 0, 1, 0, 0));
        step(1, 0, s_(32'h304, I2, 1, 0, 0, 0, 0), e_(32'h300, I1, 1, 1, 0, 1, 1, 0));
        step(1, 0, s_(32'h304, I2, 1, 0, 0, 0, 0), e_(32'h300, I1, 1, 1, 0, 1, 2, 0));
        step(1, 0, s_(32'h304, I2, 1, 0, 0, 0, 0), e_(32'h300, I1, 1, 0, 1, 0, 3, 0));

        // branch in the second stall cycle
        step(1, 0, s_(32'h308, I3, 1, 1, 8, 0, 0), e_(32'h304, I2, 1, 1, 0, 1, 3, 0));
        step(1, 0, s_(32'h400, I1, 1, 0, 0, 1, 0), e_(32'h304, I2, 1, 0, 1, 1, 4, 0));
        step(1, 0, s_(32'h404, I3, 1, 1, 1, 0, 0), e_(32'h400, 0, 0, 0, 1, 0, 4, 1));

        // memory freeze in the middle of a stall
        step(1, 0, s_(32'h408, I1, 1, 1, 2, 0, 0), e_(32'h404, I3, 1, 1, 0, 1, 4, 1));
        for (int i = 0; i < 4; i++) begin
            step(1, 0, s_(32'h408, I1, 1, 0, 0, 0, 1), e_(32'h404, I3, 1, 1, 0, 1, 5, 1));
        end
        step(1, 0, s_(32'h408, I1, 1, 0, 0, 0, 0), e_(32'h404, I3, 1, 1, 0, 1, 5, 1));
        step(1, 0, s_(32'h408, I1, 1, 0, 0, 0, 0), e_(32'h404, I3, 1, 1, 0, 1, 6, 1));
        step(1, 0, s_(32'h408, I1, 1, 0, 0, 0, 0), e_(32'h404, I3, 1, 0, 1, 0, 7, 1));
        step(1, 0, s_(32'h40C, I2, 1, 1, 3, 0, 1), e_(32'h408, I1, 1, 1, 0, 1, 7, 1));

        // saturation of both 3-bit counters
        step(1, 0, s_(32'h40C, I2, 1, 1, 3, 0, 0), e_(32'h408, I1, 1, 1, 0, 1, 7, 1));
        step(1, 0, s_(32'h500, I3, 1, 0, 0, 1, 0), e_(32'h408, I1, 1, 0, 1, 1, 7, 1));
        for (int k = 0; k < 7; k++) begin
            step(1, 0, s_(32'h600 + 32'(4 * k), I1, 1, 0, 0, 1, 0),
                 e_((k == 0) ? 32'h500 : 32'h600 + 32'(4 * (k - 1)), 0, 0, 0, 1, 1, 7,
                    (k < 5) ? 16'(2 + k) : 16'd7));
        end
        step(1, 0, s_(0, 0, 0, 0, 0, 0, 0), e_(32'h618, 0, 0, 0, 1, 0, 7, 7));

        // asynchronous reset while stalled
        step(1, 0, s_(32'h700, I1, 1, 0, 0, 0, 0), e_(0, 0, 0, 0, 1, 0, 7, 7));
        step(1, 0, s_(32'h704, I2, 1, 1, 3, 0, 0), e_(32'h700, I1, 1, 1, 0, 1, 7, 7));
        step(1, 1, s_(32'h704, I2, 1, 0, 0, 0, 0), e_(0, 0, 0, 0, 1, 0, 0, 0));
        step(1, 0, s_(32'h800, I3, 1, 1, 1, 0, 0), e_(0, 0, 0, 0, 1, 0, 0, 0));
        step(1, 0, s_(0, 0, 0, 0, 0, 0, 0),       e_(32'h800, I3, 1, 0, 1, 0, 0, 0));

        for (int w = 0; w < 10 && sb.size() > 0; w++) begin
            @(negedge clk);
        end
        #1;
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
